// File: rtl/i2c_bus_arbiter.sv
// Shares one downstream I2C path between the PS EMIO master (default owner, combinational
// pass-through) and a PL master granted the bus through a req/gnt handshake after bus-free time.
module i2c_bus_arbiter #(
   parameter int SYNC_STAGES       = 2,
   parameter int BUS_FREE_CYCLES   = 500,
   parameter int PL_TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps_scl_o,
   input  logic       ps_sda_t,
   output logic       ps_sda_i,
   input  logic       pl_scl_o,
   input  logic       pl_sda_t,
   output logic       pl_sda_i,
   input  logic       pl_req,
   output logic       pl_gnt,
   output logic       bus_scl_o,
   output logic       bus_sda_t,
   input  logic       bus_sda_i,
   output logic       ps_active,
   output logic       pl_timeout,
   output logic       collision,
   output logic [7:0] collision_count
);

   // state      | meaning
   // FREE_WAIT  | PS owns; counting idle cycles after reset, STOP or PL release
   // PS_IDLE    | PS owns; bus free, PL may be granted
   // PS_ACTIVE  | PS transaction between START and STOP
   // PL_OWN     | PL granted, timeout counter running
   // PL_RELEASE | PL lines forced released while bus-free time elapses
   typedef enum logic [2:0] {FREE_WAIT, PS_IDLE, PS_ACTIVE, PL_OWN, PL_RELEASE} state_t;

   localparam int FREE_W = $clog2(BUS_FREE_CYCLES + 1);
   localparam int TMO_W  = $clog2(PL_TIMEOUT_CYCLES + 1);
   localparam logic [FREE_W-1:0] FREE_LOAD = FREE_W'(BUS_FREE_CYCLES - 1);
   localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(PL_TIMEOUT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0]  sda_sync_q, sda_sync_d;
   logic                    sda_prev_q, sda_prev_d;
   logic [FREE_W-1:0]       free_cnt_q, free_cnt_d;
   logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic                    pl_timeout_q, pl_timeout_d;
   logic                    collision_q, collision_d;
   logic [7:0]              coll_cnt_q, coll_cnt_d;

   logic scl_s, sda_s, start_det, stop_det, sel_pl, force_rel;

   assign scl_s      = scl_sync_q[SYNC_STAGES-1];
   assign sda_s      = sda_sync_q[SYNC_STAGES-1];
   assign start_det  = scl_s & sda_prev_q & ~sda_s;
   assign stop_det   = scl_s & ~sda_prev_q & sda_s;
   assign scl_sync_d = SYNC_STAGES'({scl_sync_q, ps_scl_o});
   assign sda_sync_d = SYNC_STAGES'({sda_sync_q, ps_sda_t});
   assign sda_prev_d = sda_s;

   always_comb begin
      state_d      = state_q;
      free_cnt_d   = free_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      pl_timeout_d = 1'b0;
      collision_d  = 1'b0;
      coll_cnt_d   = coll_cnt_q;
      case (state_q)
         FREE_WAIT: begin
            if (start_det)             state_d = PS_ACTIVE;
            else if (!scl_s || !sda_s) free_cnt_d = FREE_LOAD;
            else if (free_cnt_q == '0) state_d = PS_IDLE;
            else                       free_cnt_d = free_cnt_q - 1'b1;
         end
         PS_IDLE: begin
            if (start_det) state_d = PS_ACTIVE;
            else if (pl_req && scl_s && sda_s) begin
               state_d   = PL_OWN;
               tmo_cnt_d = TMO_LOAD;
            end
         end
         PS_ACTIVE: begin
            if (stop_det) begin
               state_d    = FREE_WAIT;
               free_cnt_d = FREE_LOAD;
            end
         end
         PL_OWN: begin
            // PS START while PL owns the bus: flag it, PL keeps ownership
            if (start_det) begin
               collision_d = 1'b1;
               if (coll_cnt_q != 8'hFF) coll_cnt_d = coll_cnt_q + 8'd1;
            end
            if (!pl_req) begin
               state_d    = PL_RELEASE;
               free_cnt_d = FREE_LOAD;
            end else if (tmo_cnt_q == '0) begin
               state_d      = PL_RELEASE;
               free_cnt_d   = FREE_LOAD;
               pl_timeout_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q - 1'b1;
            end
         end
         PL_RELEASE: begin
            if (free_cnt_q != '0) free_cnt_d = free_cnt_q - 1'b1;
            else if (!pl_req) begin
               state_d    = FREE_WAIT;
               free_cnt_d = FREE_LOAD;
            end
         end
         default: state_d = FREE_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FREE_WAIT;
         scl_sync_q   <= '1;
         sda_sync_q   <= '1;
         sda_prev_q   <= 1'b1;
         free_cnt_q   <= FREE_LOAD;
         tmo_cnt_q    <= TMO_LOAD;
         pl_timeout_q <= 1'b0;
         collision_q  <= 1'b0;
         coll_cnt_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         scl_sync_q   <= scl_sync_d;
         sda_sync_q   <= sda_sync_d;
         sda_prev_q   <= sda_prev_d;
         free_cnt_q   <= free_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         pl_timeout_q <= pl_timeout_d;
         collision_q  <= collision_d;
         coll_cnt_q   <= coll_cnt_d;
      end
   end

   // Select decodes straight from the state register, so reset reverts the mux asynchronously
   assign sel_pl    = (state_q == PL_OWN) || (state_q == PL_RELEASE);
   assign force_rel = (state_q == PL_RELEASE);

   assign bus_scl_o       = force_rel | (sel_pl ? pl_scl_o : ps_scl_o);
   assign bus_sda_t       = force_rel | (sel_pl ? pl_sda_t : ps_sda_t);
   assign ps_sda_i        = bus_sda_i;
   assign pl_sda_i        = sel_pl ? bus_sda_i : 1'b1;
   assign pl_gnt          = (state_q == PL_OWN);
   assign ps_active       = (state_q == PS_ACTIVE);
   assign pl_timeout      = pl_timeout_q;
   assign collision       = collision_q;
   assign collision_count = coll_cnt_q;

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Shares the single downstream I2C path (the merged CLK/CAL bus fed through `i2c_merger`) between the PS EMIO I2C master and one PL-side I2C master, such as the optional TURFIO I2C controls. The PS always has default ownership with zero-latency pass-through. The PL master gets the bus only through a request/grant handshake, and only after the PS bus has been idle for a programmable bus-free time. The block sits between `zynq_bd_wrapper` and `i2c_merger`. It tracks PS transactions by detecting START and STOP conditions, and it flags any PS traffic that collides with a PL grant.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for the PS lines (PS lines are asynchronous to `clk`).
- `BUS_FREE_CYCLES`, 500: idle `clk` cycles required after a STOP, or after a PL release, before a grant (5 µs at 100 MHz).
- `PL_TIMEOUT_CYCLES`, 1000000: maximum continuous PL ownership before forced release.

Ports:
- `clk` in 1: system clock (`ps_clk`).
- `rst` in 1: asynchronous, active-high reset.
- `ps_scl_o` in 1: PS SCL; 0 = drive low.
- `ps_sda_t` in 1: PS SDA tristate; 1 = release.
- `ps_sda_i` out 1: SDA returned to the PS.
- `pl_scl_o` in 1: PL SCL; synchronous to `clk`.
- `pl_sda_t` in 1: PL SDA tristate; synchronous to `clk`.
- `pl_sda_i` out 1: SDA returned to the PL master.
- `pl_req` in 1: PL bus request; level.
- `pl_gnt` out 1: PL bus grant; level.
- `bus_scl_o` out 1: SCL to `i2c_merger`.
- `bus_sda_t` out 1: SDA tristate to `i2c_merger`.
- `bus_sda_i` in 1: SDA from `i2c_merger`.
- `ps_active` out 1: PS transaction in progress (START seen, no STOP yet).
- `pl_timeout` out 1: one-cycle pulse on forced release.
- `collision` out 1: one-cycle pulse when a PS START is seen during PL ownership.
- `collision_count` out 8: saturating count of collisions.

## Operation
- Owner select is a registered mux with value PS or PL.
  - PS selected: `bus_scl_o`=`ps_scl_o` and `bus_sda_t`=`ps_sda_t`, both combinational. `pl_sda_i`=1.
  - PL selected: `bus_scl_o`=`pl_scl_o` and `bus_sda_t`=`pl_sda_t`. `pl_sda_i`=`bus_sda_i`.
  - `ps_sda_i`=`bus_sda_i` always, so the PS's own multi-master logic sees PL traffic.
- Detection runs on the synchronized PS lines (`SYNC_STAGES` flops, then one edge register):
  - START: `ps_sda_t` falls while `ps_scl_o`=1.
  - STOP: `ps_sda_t` rises while `ps_scl_o`=1.
- States:
  - FREE_WAIT (reset state). Select=PS. The counter loads `BUS_FREE_CYCLES`-1 on entry and decrements each cycle. It reloads whenever either synced PS line is low. Goes to PS_IDLE at 0. A START goes to PS_ACTIVE.
  - PS_IDLE. Select=PS. A START goes to PS_ACTIVE; START has priority over `pl_req` in the same cycle. `pl_req`=1 with both synced PS lines high goes to PL_OWN.
  - PS_ACTIVE. Select=PS, `ps_active`=1. A STOP goes to FREE_WAIT. `pl_req` is ignored.
  - PL_OWN. Select=PL, `pl_gnt`=1, and the timeout counter runs. `pl_req`=0 goes to PL_RELEASE. Reaching `PL_TIMEOUT_CYCLES` pulses `pl_timeout` and goes to PL_RELEASE. A START pulses `collision` and increments `collision_count`, saturating at 255; the PS lines are not forwarded and the state is unchanged.
  - PL_RELEASE. Select=PL with `bus_scl_o`=1 and `bus_sda_t`=1 forced, `pl_gnt`=0. Counts `BUS_FREE_CYCLES`. At 0, if `pl_req`=0, goes to FREE_WAIT with select=PS. If `pl_req` is still high after a timeout, it holds here until `pl_req`=0, so there is no re-grant without a request drop.
- The PL master must hold SCL and SDA released whenever `pl_gnt`=0 and must not drive them until it sees `pl_gnt`=1.

## Timing
- Reset values:
  - `pl_gnt`=0, `ps_active`=0, `pl_timeout`=0, `collision`=0, `collision_count`=0.
  - Select=PS, so bus outputs follow the PS lines and `pl_sda_i`=1.
- START/STOP detection latency: `SYNC_STAGES`+1 `clk` cycles after the PS edge.
- Grant latency: `pl_gnt` rises 1 cycle after `pl_req` is sampled high in PS_IDLE.
- Release: `pl_gnt` falls 1 cycle after `pl_req` is sampled low. Bus lines are forced released in the same cycle.
- After power-up, PL release, or STOP, a PL grant comes no sooner than `BUS_FREE_CYCLES` cycles of continuously idle PS lines.
- A PS START in the `SYNC_STAGES`+1 window around a grant is detected in PL_OWN. It is handled as a collision; the PL keeps the bus.
- Reset mid-transaction, including during PL_OWN: the bus immediately reverts to the PS mux and `pl_gnt` drops asynchronously.

## Test plan
- Reset, hold both PS lines idle, `pl_req`=1 at cycle 0 → `pl_gnt`=0 until cycle ≥500, then 1. The bus follows the PL lines.
- PS START, a byte, then STOP, with `pl_req` raised mid-transfer → `ps_active`=1 from START+3 cycles. `pl_gnt` rises exactly 501 cycles after STOP+3.
- PL granted, `pl_req` dropped → `pl_gnt`=0 next cycle. The bus is held released for 500 cycles, then the PS mux returns.
- PL granted with `pl_req` held for 1000000 cycles → `pl_timeout` pulses once. No re-grant until `pl_req` toggles low and high again.
- During PL_OWN, issue 300 PS STARTs → 300 `collision` pulses, `collision_count`=255, and the bus continues to follow the PL lines.
- Assert `rst` during PL_OWN with the PL driving SDA low → `pl_gnt`=0 and the bus follows the PS lines within the same cycle.
